sevseg_scan_ctrl: RTL and testbench



---
 rtl/sevseg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_sevseg_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with frame-synchronous content commit.
// Optional digit blinking is compiled in when SEVSEG_BLINK_EN is defined.
module sevseg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] dig_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  blink_in,
    output logic [3:0]  dig_val,
    output logic [3:0]  anode,
    output logic        upd_ack,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0] pcnt;
    logic [1:0]    slot;
    logic [1:0]    slotNext;
    logic          termCnt;
    logic          commit;

    logic [15:0] pendDig;
    logic [3:0]  pendBlank;
    logic        pend;
    logic [15:0] actDig;
    logic [3:0]  actBlank;
    logic [15:0] actDigNext;
    logic [3:0]  actBlankNext;
    logic [3:0]  darkNext;

    assign termCnt    = (pcnt == PW'(REFRESH_DIV - 1));
    assign frame_done = termCnt && (slot == 2'd3);
    assign commit     = frame_done && (load || pend);
    assign slotNext   = slot + 2'd1;

    // Outputs are registered from the post-commit values so new content lands in slot 0.
    always_comb begin
        actDigNext   = actDig;
        actBlankNext = actBlank;
        if (frame_done) begin
            if (load) begin
                actDigNext   = dig_in;
                actBlankNext = blank_in;
            end else if (pend) begin
                actDigNext   = pendDig;
                actBlankNext = pendBlank;
            end
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [3:0]    pendBlink;
    logic [3:0]    actBlink;
    logic [3:0]    actBlinkNext;
    logic [FW-1:0] fcnt;
    logic          fcntLast;
    logic          bphase;
    logic          bphaseNext;

    assign fcntLast = (fcnt == FW'(BLINK_DIV - 1));

    always_comb begin
        actBlinkNext = actBlink;
        if (frame_done) begin
            if (load) begin
                actBlinkNext = blink_in;
            end else if (pend) begin
                actBlinkNext = pendBlink;
            end
        end
        bphaseNext = (frame_done && fcntLast) ? ~bphase : bphase;
        darkNext   = actBlankNext | (actBlinkNext & {4{bphaseNext}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pendBlink <= '0;
            actBlink  <= '0;
            fcnt      <= '0;
            bphase    <= 1'b0;
        end else begin
            actBlink <= actBlinkNext;
            bphase   <= bphaseNext;
            if (load && !frame_done) begin
                pendBlink <= blink_in;
            end
            if (frame_done) begin
                fcnt <= fcntLast ? '0 : fcnt + 1'b1;
            end
        end
    end
`else
    localparam int unusedBlinkDiv = BLINK_DIV;
    logic unusedBlink;

    assign unusedBlink = ^blink_in;

    always_comb begin
        darkNext = actBlankNext;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt      <= '0;
            slot      <= '0;
            pend      <= 1'b0;
            pendDig   <= '0;
            pendBlank <= '1;
            actDig    <= '0;
            actBlank  <= '1;
            dig_val   <= '0;
            anode     <= '1;
            upd_ack   <= 1'b0;
        end else begin
            pcnt     <= termCnt ? '0 : pcnt + 1'b1;
            upd_ack  <= commit;
            actDig   <= actDigNext;
            actBlank <= actBlankNext;
            if (frame_done) begin
                pend <= 1'b0;
            end else if (load) begin
                pend      <= 1'b1;
                pendDig   <= dig_in;
                pendBlank <= blank_in;
            end
            if (termCnt) begin
                slot    <= slotNext;
                dig_val <= actDigNext[slotNext*4 +: 4];
                anode   <= darkNext[slotNext] ? 4'b1111 : ~(4'b0001 << slotNext);
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl with REFRESH_DIV=4, BLINK_DIV=2 (16-clock frames).
module tb_sevseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] dig_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic [3:0]  dig_val;
    logic [3:0]  anode;
    logic        upd_ack;
    logic        frame_done;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    sevseg_scan_ctrl #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk), .rst(rst), .load(load), .dig_in(dig_in), .blank_in(blank_in),
        .blink_in(blink_in), .dig_val(dig_val), .anode(anode), .upd_ack(upd_ack),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  blank;
        logic [15:0] expA;   // anode per slot, slot s at [4s+3:4s]
        logic [15:0] expV;   // dig_val per slot
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d t=%0t", name, act, exp, cyc, $time);
        end
    endtask

    task automatic doLoad(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
        dig_in = d;
        blank_in = bl;
        blink_in = bk;
        load = 1'b1;
        tick();
        load = 1'b0;
        blink_in = '0;
    endtask

    task automatic waitAck();
        for (int i = 0; i < 40; i++) begin
            if (upd_ack) break;
            tick();
        end
        chk("ackSeen", 32'(upd_ack), 32'd1);
        chk("ackAlign", cyc % 16, 32'd0);
    endtask

    task automatic checkScan(input logic [15:0] expA, input logic [15:0] expV);
        for (int k = 0; k < 16; k++) begin
            int s;
            s = k / 4;
            chk("scanAnode", 32'(anode), 32'(expA[s*4 +: 4]));
            chk("scanVal", 32'(dig_val), 32'(expV[s*4 +: 4]));
            chk("scanAck", 32'(upd_ack), (k == 0) ? 32'd1 : 32'd0);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{dig: 16'h0210, blank: 4'b0000, expA: 16'h7BDE, expV: 16'h0210};
        vecs[1] = '{dig: 16'hA5C3, blank: 4'b0101, expA: 16'h7FDF, expV: 16'hA5C3};
        vecs[2] = '{dig: 16'hFFFF, blank: 4'b1111, expA: 16'hFFFF, expV: 16'hFFFF};
        vecs[3] = '{dig: 16'h9876, blank: 4'b1000, expA: 16'hFBDE, expV: 16'h9876};

        // Reset and idle dark frames
        #1;
        repeat (3) tick();
        chk("rstAnode", 32'(anode), 32'hF);
        chk("rstVal", 32'(dig_val), 32'h0);
        chk("rstAck", 32'(upd_ack), 32'd0);
        chk("rstFd", 32'(frame_done), 32'd0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 48; c++) begin
            chk("idleAnode", 32'(anode), 32'hF);
            chk("idleFd", 32'(frame_done), (c % 16 == 15) ? 32'd1 : 32'd0);
            chk("idleAck", 32'(upd_ack), 32'd0);
            tick();
        end

        // Table-driven scan patterns, each loaded mid-frame
        for (int v = 0; v < 4; v++) begin
            tick();
            doLoad(vecs[v].dig, vecs[v].blank, 4'b0000);
            waitAck();
            checkScan(vecs[v].expA, vecs[v].expV);
        end

        // Overwrite before the boundary: one ack, last value wins
        tick();
        doLoad(16'h1111, 4'b0000, 4'b0000);
        tick();
        tick();
        doLoad(16'h2222, 4'b0000, 4'b0000);
        waitAck();
        checkScan(16'h7BDE, 16'h2222);

        // Load on the frame_done cycle bypasses pending
        for (int i = 0; i < 40; i++) begin
            if (frame_done) break;
            tick();
        end
        chk("fdSeen", 32'(frame_done), 32'd1);
        doLoad(16'h0001, 4'b0000, 4'b0000);
        chk("bypAck", 32'(upd_ack), 32'd1);
        chk("bypAnode", 32'(anode), 32'hE);
        chk("bypVal", 32'(dig_val), 32'h1);
        doLoad(16'h0003, 4'b0000, 4'b0000);
        waitAck();
        checkScan(16'h7BDE, 16'h0003);

        // Blank digit 3, blink digit 0
        doLoad(16'h4321, 4'b1000, 4'b0001);
        waitAck();
        for (int k = 0; k < 64; k++) begin
            int unsigned f;
            int unsigned s;
            logic [3:0] ea;
            f = cyc / 16;
            s = (cyc % 16) / 4;
            ea = (s == 3) ? 4'b1111 : ~(4'b0001 << s);
`ifdef SEVSEG_BLINK_EN
            if (s == 0 && ((f / 2) % 2 == 1)) ea = 4'b1111;
`else
            if (f > 100000) ea = 4'b0000;
`endif
            chk("blinkAnode", 32'(anode), 32'(ea));
            chk("blinkVal", 32'(dig_val), s + 1);
            tick();
        end

        // Reset while a load is pending
        doLoad(16'h5555, 4'b0000, 4'b0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        chk("midRstAnode", 32'(anode), 32'hF);
        chk("midRstVal", 32'(dig_val), 32'h0);
        for (int c = 0; c < 40; c++) begin
            chk("midRstAck", 32'(upd_ack), 32'd0);
            chk("midRstDark", 32'(anode), 32'hF);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
